// File: rtl/pcie_bram_fifo_ctrl.sv
// Streaming FIFO controller around a 2-cycle-latency BRAM buffer.
// Reads are issued ahead of demand and land in a 4-entry skid buffer so back-pressure never drops data.
module pcie_bram_fifo_ctrl #(
    parameter int unsigned DEPTH  = 11,
    parameter int unsigned DATA_W = 72
) (
    input  logic              user_clk_i,
    input  logic              reset_n_i,
    input  logic              flush_i,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              ram_wen,
    output logic [12:0]       ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_ren,
    output logic              ram_rce,
    output logic [12:0]       ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DEPTH:0]    level
);

    localparam logic [DEPTH:0] Full    = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0] PtrOne  = {{DEPTH{1'b0}}, 1'b1};

    logic [DEPTH:0]    wp, rp, used;
    logic [1:0]        infl;
    logic [2:0]        sc;
    logic [1:0]        skid_wr, skid_rd;
    logic [DATA_W-1:0] skid_mem [4];

    logic              clr, wr_fire, push, pop;
    logic [3:0]        occ;

    always_comb begin
        clr       = !reset_n_i || flush_i;
        used      = wp - rp;
        s_ready   = clr || (used != Full);
        wr_fire   = s_valid && s_ready && !clr;
        ram_wen   = wr_fire;
        ram_waddr = 13'(wp[DEPTH-1:0]);
        ram_wdata = s_data;
        m_valid   = (sc != 3'd0) && !clr;
        pop       = m_valid && m_ready;
        push      = infl[1];
        // Count every skid slot already owed: held words plus reads still in the RAM pipe.
        occ       = {1'b0, sc} + {3'b000, infl[0]} + {3'b000, infl[1]} - {3'b000, pop};
        ram_ren   = !clr && (used != '0) && (occ < 4'd4);
        ram_raddr = 13'(rp[DEPTH-1:0]);
        ram_rce   = 1'b1;
        level     = clr ? '0 : used;
        m_data    = skid_mem[skid_rd];
    end

    always_ff @(posedge user_clk_i) begin
        if (!reset_n_i || flush_i) begin
            wp      <= '0;
            rp      <= '0;
            infl    <= 2'b00;
            sc      <= 3'd0;
            skid_wr <= 2'd0;
            skid_rd <= 2'd0;
        end else begin
            if (wr_fire) wp <= wp + PtrOne;
            if (ram_ren) rp <= rp + PtrOne;
            infl <= {infl[0], ram_ren};
            if (push) skid_wr <= skid_wr + 2'd1;
            if (pop)  skid_rd <= skid_rd + 2'd1;
            sc <= sc + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge user_clk_i) begin
        if (push && !clr) skid_mem[skid_wr] <= ram_rdata;
    end

endmodule

// File: tb/tb_pcie_bram_fifo_ctrl.sv
// Self-checking bench for pcie_bram_fifo_ctrl with a behavioural 2-cycle BRAM and a data scoreboard.
module tb_pcie_bram_fifo_ctrl;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 72;

    logic              clk = 1'b0;
    logic              rst_n, flush;
    logic              s_valid, s_ready, m_valid, m_ready;
    logic [DATA_W-1:0] s_data, m_data;
    logic              ram_wen, ram_ren, ram_rce;
    logic [12:0]       ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata, ram_s1;
    logic [DEPTH:0]    level;

    logic [DATA_W-1:0] ram_mem [16];
    logic [DATA_W-1:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;
    int wr_total = 0;
    int rd_total = 0;

    pcie_bram_fifo_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .user_clk_i(clk), .reset_n_i(rst_n), .flush_i(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_ren(ram_ren), .ram_rce(ram_rce), .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata), .level(level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wen) ram_mem[ram_waddr[3:0]] <= ram_wdata;
        if (ram_ren) ram_s1 <= ram_mem[ram_raddr[3:0]];
        ram_rdata <= ram_s1;
    end

    // Reference write/read counts since the last clear, taken from the handshakes the bench drives.
    always @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_total = 0;
            rd_total = 0;
        end else begin
            if (s_valid && s_ready) wr_total = wr_total + 1;
            if (ram_ren) rd_total = rd_total + 1;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        for (int i = 0; i < 3; i++) next_cycle();
        @(negedge clk);
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rst_s_ready: got %b expected 1", s_ready); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL rst_level: got %0d expected 0", level); end
        n_cmp++; if (ram_ren !== 1'b0) begin n_err++; $display("FAIL rst_ram_ren: got %b expected 0", ram_ren); end
        n_cmp++; if (ram_rce !== 1'b1) begin n_err++; $display("FAIL rst_ram_rce: got %b expected 1", ram_rce); end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (ram_wen !== 1'b0 || ram_ren !== 1'b0 || m_valid !== 1'b0 || level !== '0)
            begin n_err++; $display("FAIL post_rst_idle: got wen=%b ren=%b mv=%b lvl=%0d expected 0 0 0 0",
                                    ram_wen, ram_ren, m_valid, level); end
        next_cycle();
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] e;
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_valid = (i < 5);
            s_data  = DATA_W'(i + 1);
            @(negedge clk);
            if (s_valid && s_ready) exp_q.push_back(s_data);
            n_cmp++;
            if (m_valid !== (i >= 4 && i <= 8)) begin
                n_err++; $display("FAIL basic_m_valid cyc%0d: got %b expected %b", i, m_valid, (i >= 4 && i <= 8));
            end
            if (m_valid && m_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL basic_pop: got %h expected none", m_data); end
                else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin n_err++; $display("FAIL basic_data: got %h expected %h", m_data, e); end
                end
            end
            next_cycle();
        end
        s_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL basic_level: got %0d expected 0", level); end
        next_cycle();
    endtask

    task automatic test_full();
        logic [DATA_W-1:0] e;
        int acc = 0;
        int got = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            s_valid = 1'b1;
            s_data  = {8'hF0, 32'(acc), 32'hCAFE0000 + 32'(acc)};
            @(negedge clk);
            if (i == 16) begin
                n_cmp++; if (level !== 5'd12) begin n_err++; $display("FAIL full_level12: got %0d expected 12", level); end
            end
            if (s_valid && s_ready) begin exp_q.push_back(s_data); acc++; end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++; if (acc != 20) begin n_err++; $display("FAIL full_accepted: got %0d expected 20", acc); end
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL full_s_ready: got %b expected 0", s_ready); end
        n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL full_level16: got %0d expected 16", level); end
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL full_m_valid: got %b expected 1", m_valid); end
        next_cycle();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 80 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                n_cmp++;
                e = exp_q.pop_front();
                got++;
                if (m_data !== e) begin n_err++; $display("FAIL drain_data: got %h expected %h", m_data, e); end
            end
            next_cycle();
        end
        n_cmp++; if (got != 20) begin n_err++; $display("FAIL drain_count: got %0d expected 20", got); end
        exp_q.delete();
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0 || level !== '0)
            begin n_err++; $display("FAIL drain_empty: got mv=%b lvl=%0d expected 0 0", m_valid, level); end
        next_cycle();
    endtask

    task automatic test_toggle();
        logic [DATA_W-1:0] e;
        int sent = 0;
        int got = 0;
        for (int i = 0; i < 1000 && (sent < 100 || exp_q.size() > 0); i++) begin
            s_valid = (sent < 100);
            s_data  = {8'(sent), $urandom(), $urandom()};
            m_ready = (i % 4 == 0) || (i % 4 == 3);
            @(negedge clk);
            if (s_valid && s_ready) begin exp_q.push_back(s_data); sent++; end
            if (m_valid && m_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL toggle_pop: got %h expected none", m_data); end
                else begin
                    e = exp_q.pop_front();
                    got++;
                    if (m_data !== e) begin n_err++; $display("FAIL toggle_data: got %h expected %h", m_data, e); end
                end
            end
            next_cycle();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        n_cmp++; if (got != 100) begin n_err++; $display("FAIL toggle_count: got %0d expected 100", got); end
        exp_q.delete();
        for (int i = 0; i < 6; i++) next_cycle();
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] e;
        int sent = 0;
        int got = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 200 && (sent < 40 || exp_q.size() > 0); i++) begin
            s_valid = (sent < 40);
            s_data  = {8'hA5, 32'(sent), $urandom()};
            @(negedge clk);
            if (s_valid && s_ready) begin
                n_cmp++;
                if (ram_waddr !== 13'(wr_total % 16) || ram_wdata !== s_data) begin
                    n_err++; $display("FAIL wrap_waddr: got %0d expected %0d", ram_waddr, wr_total % 16);
                end
                exp_q.push_back(s_data); sent++;
            end
            if (ram_ren) begin
                n_cmp++;
                if (ram_raddr !== 13'(rd_total % 16)) begin
                    n_err++; $display("FAIL wrap_raddr: got %0d expected %0d", ram_raddr, rd_total % 16);
                end
            end
            if (m_valid && m_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL wrap_pop: got %h expected none", m_data); end
                else begin
                    e = exp_q.pop_front();
                    got++;
                    if (m_data !== e) begin n_err++; $display("FAIL wrap_data: got %h expected %h", m_data, e); end
                end
            end
            next_cycle();
        end
        s_valid = 1'b0;
        n_cmp++; if (got != 40) begin n_err++; $display("FAIL wrap_count: got %0d expected 40", got); end
        exp_q.delete();
        next_cycle();
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] e;
        int stray = 0;
        int got = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = DATA_W'(8'h50 + i);
            @(negedge clk);
            if (i == 2) begin
                n_cmp++; if (ram_ren !== 1'b1) begin n_err++; $display("FAIL flush_pre_ren: got %b expected 1", ram_ren); end
            end
            next_cycle();
        end
        s_valid = 1'b0;
        flush   = 1'b1;
        next_cycle();
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL flush_m_valid: got %b expected 0", m_valid); end
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL flush_level: got %0d expected 0", level); end
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL flush_s_ready: got %b expected 1", s_ready); end
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            @(negedge clk);
            if (m_valid !== 1'b0) stray++;
        end
        n_cmp++; if (stray != 0) begin n_err++; $display("FAIL flush_late_push: got %0d valid cycles expected 0", stray); end
        next_cycle();
        s_valid = 1'b1;
        s_data  = DATA_W'(8'hAA);
        m_ready = 1'b1;
        @(negedge clk);
        if (s_valid && s_ready) exp_q.push_back(s_data);
        next_cycle();
        s_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                n_cmp++;
                got++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL flush_extra: got %h expected none", m_data); end
                else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin n_err++; $display("FAIL flush_aa: got %h expected %h", m_data, e); end
                end
            end
            next_cycle();
        end
        n_cmp++; if (got != 1) begin n_err++; $display("FAIL flush_aa_count: got %0d expected 1", got); end
        exp_q.delete();
    endtask

    task automatic test_reset_handshake();
        int stray = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_valid = (i < 2);
            s_data  = DATA_W'(8'h30 + i);
            next_cycle();
        end
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL rh_pre_valid: got %b expected 1", m_valid); end
        next_cycle();
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = DATA_W'(8'h77);
        m_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (ram_wen !== 1'b0 || ram_ren !== 1'b0)
            begin n_err++; $display("FAIL rh_during: got wen=%b ren=%b expected 0 0", ram_wen, ram_ren); end
        next_cycle();
        rst_n   = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rh_m_valid: got %b expected 0", m_valid); end
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL rh_level: got %0d expected 0", level); end
        n_cmp++; if (s_ready !== 1'b1 || ram_ren !== 1'b0)
            begin n_err++; $display("FAIL rh_ready_ren: got rdy=%b ren=%b expected 1 0", s_ready, ram_ren); end
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            @(negedge clk);
            if (m_valid !== 1'b0 || level !== '0) stray++;
        end
        n_cmp++; if (stray != 0) begin n_err++; $display("FAIL rh_stale: got %0d bad cycles expected 0", stray); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_toggle();
        test_wrap();
        test_flush();
        test_reset_handshake();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
